// File: rtl/serial_add_sub_unit_pkg.sv
// Shared ALU definitions: datapath width, op-select codes and the serial unit's state encoding.
package serial_add_sub_unit_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_sub_unit_if.sv
// Start/done operand and result bundle between an ALU sequencer and the serial add/sub unit.
interface serial_add_sub_unit_if
    import serial_add_sub_unit_pkg::*;
    #(parameter int WIDTH = ALU_WIDTH);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, A, B,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, result, cout, overflow
    );

endinterface

// File: rtl/serial_add_sub_unit_full_adder.sv
// Existing 1-bit full adder cell reused by the bit-serial add/sub datapath.
module full_adder (
    input  logic Ai,
    input  logic Bi,
    input  logic Cini,
    output logic Di,
    output logic Couti
);

    assign Di    = Ai ^ Bi ^ Cini;
    assign Couti = (Ai & Bi) | (Cini & (Ai ^ Bi));

endmodule

// File: rtl/serial_add_sub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor: one full_adder, LSB first, one operation per WIDTH+2 cycles.
//   state   | meaning
//   ST_IDLE | waiting for start; result/cout/overflow hold the last operation
//   ST_RUN  | one operand bit pair summed per clock, busy = 1
//   ST_DONE | single-cycle done pulse, then back to ST_IDLE
module serial_add_sub_unit
    import serial_add_sub_unit_pkg::*;
    #(parameter int WIDTH = ALU_WIDTH)
(
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_sub_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_full_adder (
        .Ai    (a_sr[0]),
        .Bi    (b_sr[0]),
        .Cini  (carry),
        .Di    (fa_sum),
        .Couti (fa_cout)
    );

    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            result_q <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.A;
                        b_sr  <= bus.B ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    result_q <= {fa_sum, result_q[WIDTH-1:1]};
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    carry    <= fa_cout;
                    cnt      <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        cout_q <= fa_cout;
                        ovf_q  <= carry ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Self-checking bench for serial_add_sub_unit: directed corner cases, reset abort, held start, random ops.
module tb_serial_add_sub_unit;
    import serial_add_sub_unit_pkg::*;

    localparam int W = ALU_WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_add_sub_unit_if #(.WIDTH(W)) bus ();

    serial_add_sub_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) assert (!(bus.busy && bus.done));
    end

    // Reference: plain modular, unsigned and signed arithmetic on the operands.
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] r, output logic c, output logic v);
        longint sa;
        longint sb;
        longint sres;
        longint ua;
        longint ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sres = s ? (sa - sb) : (sa + sb);
        v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        r = s ? (a - b) : (a + b);
        c = s ? (a >= b) : ((ua + ub) >= 64'h1_0000_0000);
    endfunction

    // Entered at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold,
                         input logic [31:0] er, input logic ec, input logic ev, input string tag);
        int lat;
        int busy_n;
        lat = 0;
        busy_n = 0;
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.sub = s;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1 && !hold) bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_n++;
            bus.A = $urandom;
            bus.B = $urandom;
            bus.sub = 1'($urandom_range(0, 1));
        end
        check_val({tag, ".latency"}, 64'(lat), 64'd33);
        check_val({tag, ".busy_cycles"}, 64'(busy_n), 64'(W));
        check_val({tag, ".result"}, 64'(bus.result), 64'(er));
        check_val({tag, ".cout"}, 64'(bus.cout), 64'(ec));
        check_val({tag, ".overflow"}, 64'(bus.overflow), 64'(ev));
        check_val({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_val({tag, ".done_width"}, 64'(bus.done), 64'd0);
        check_val({tag, ".idle_gap"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic do_rand(input bit hold, input string tag);
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        c;
        logic        v;
        a = $urandom;
        b = $urandom;
        s = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) b = a;
        ref_op(a, b, s, r, c, v);
        do_op(a, b, s, hold, r, c, v, tag);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sub = OP_ADD;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(negedge clk);
        check_val("rst.busy", 64'(bus.busy), 64'd0);
        check_val("rst.done", 64'(bus.done), 64'd0);
        check_val("rst.result", 64'(bus.result), 64'd0);
        check_val("rst.cout_ovf", 64'({bus.cout, bus.overflow}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h0000_0005, 32'h0000_0003, OP_ADD, 1'b0, 32'h0000_0008, 1'b0, 1'b0, "add");
        do_op(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "carry_wrap");
        do_op(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_add");
        do_op(32'h0000_0005, 32'h0000_0007, OP_SUB, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        do_op(32'h0000_0007, 32'h0000_0005, OP_SUB, 1'b0, 32'h0000_0002, 1'b1, 1'b0, "sub_pos");
        do_op(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, "ovf_sub");

        // Abort an in-flight add while cout/overflow still hold 1 from the previous op.
        bus.start = 1'b1;
        bus.sub = OP_ADD;
        bus.A = 32'h1234_5678;
        bus.B = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort.busy", 64'(bus.busy), 64'd0);
        check_val("abort.done", 64'(bus.done), 64'd0);
        check_val("abort.result", 64'(bus.result), 64'd0);
        check_val("abort.cout", 64'(bus.cout), 64'd0);
        check_val("abort.overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check_val("abort.no_done", 64'(done_seen), 64'd0);
        do_op(32'h0000_0001, 32'h0000_0001, OP_ADD, 1'b0, 32'h0000_0002, 1'b0, 1'b0, "post_abort");

        for (int i = 0; i < 6; i++) do_rand(1'b1, "held_start");
        for (int i = 0; i < 200; i++) do_rand(1'($urandom_range(0, 1)), "random");
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
